// File: rtl/pipe_reg_chain.sv
// Configurable chain of pipeline registers with valid tracking, per-stage stall/flush,
// output backpressure and forwarding taps on every stage.
module pipe_reg_chain #(
    parameter int STAGES = 4,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic [STAGES-1:0]          stall_i,
    input  logic [STAGES-1:0]          flush_i,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [STAGES-1:0]          stage_valid_o,
    output logic [STAGES*DATA_W-1:0]   stage_data_o,
    output logic [31:0]                stall_cnt_o
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] hold;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [31:0]       stall_cnt_q;

    // Hold ripples from the output side toward stage 0; a running scalar keeps
    // the chain free of self-referencing vector bits.
    always_comb begin
        logic h;
        hold = '0;
        h    = stall_i[STAGES-1] | (valid_q[STAGES-1] & ~out_ready);
        hold[STAGES-1] = h;
        for (int k = STAGES - 2; k >= 0; k--) begin
            h       = stall_i[k] | h;
            hold[k] = h;
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
        end

        if (flush_i[0]) begin
            valid_d[0] = 1'b0;
            data_d[0]  = '0;
        end else if (!hold[0]) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_valid ? in_data : '0;
        end

        // A stage only inherits its upstream neighbour when that neighbour is
        // moving and not being killed; otherwise it takes a zeroed bubble.
        for (int k = 1; k < STAGES; k++) begin
            if (flush_i[k]) begin
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
            end else if (!hold[k]) begin
                if (!hold[k-1] && !flush_i[k-1] && valid_q[k-1]) begin
                    valid_d[k] = 1'b1;
                    data_d[k]  = data_q[k-1];
                end else begin
                    valid_d[k] = 1'b0;
                    data_d[k]  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
            if (in_valid && hold[0]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        stage_data_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_data_o[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

    assign in_ready      = ~hold[0];
    assign out_valid     = valid_q[STAGES-1];
    assign out_data      = data_q[STAGES-1];
    assign stage_valid_o = valid_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: expected output beats are queued per scenario
// and a forked monitor pops and compares them whenever the last stage transfers.
module tb_pipe_reg_chain;

    localparam int S = 4;
    localparam int W = 64;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic [S-1:0]   stall_i;
    logic [S-1:0]   flush_i;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [S-1:0]   stage_valid_o;
    logic [S*W-1:0] stage_data_o;
    logic [31:0]    stall_cnt_o;

    int          errors;
    int          checks;
    bit          done;
    logic [W-1:0] exp_q [$];

    pipe_reg_chain #(.STAGES(S), .DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .stage_valid_o(stage_valid_o),
        .stage_data_o (stage_data_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic run_tests();
        // reset state
        rst = 1'b1; in_valid = 1'b0; in_data = '0; stall_i = '0; flush_i = '0; out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall_cnt", stall_cnt_o, 0);
        step();
        check("rst_stage_valid", stage_valid_o, 0);
        rst = 1'b1;

        // streaming 1..8
        for (int i = 1; i <= 8; i++) exp_q.push_back(W'(i));
        for (int i = 1; i <= 8; i++) begin
            send(W'(i));
            check("stream_out_valid", out_valid, (i >= 4) ? 1 : 0);
            if (i >= 4) check("stream_out_data", out_data, i - 3);
        end
        drain(4);
        check("stream_empty", stage_valid_o, 0);
        check("stream_stall_cnt", stall_cnt_o, 0);

        // mid-chain stall on stage 1 for two cycles with a full chain
        for (int i = 'h21; i <= 'h26; i++) exp_q.push_back(W'(i));
        send('h21); send('h22); send('h23); send('h24);
        in_data = 'h25; stall_i = 4'b0010;
        #1 check("stall_in_ready_1", in_ready, 0);
        step();
        check("stall_frozen_s1s0", stage_data_o[127:0], {64'h23, 64'h24});
        check("stall_out_data", out_data, 'h22);
        #1 check("stall_in_ready_2", in_ready, 0);
        step();
        check("stall_bubble_1", out_valid, 0);
        check("stall_frozen_2", stage_data_o[127:0], {64'h23, 64'h24});
        stall_i = '0;
        send('h25);
        check("stall_bubble_2", out_valid, 0);
        send('h26);
        check("stall_resume", out_data, 'h23);
        drain(4);
        check("stall_cnt_2", stall_cnt_o, 2);

        // backpressure for three cycles with a full chain
        for (int i = 'h31; i <= 'h35; i++) exp_q.push_back(W'(i));
        send('h31); send('h32); send('h33); send('h34);
        in_data = 'h35; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check("bp_in_ready", in_ready, 0);
            step();
            check("bp_stage_data", stage_data_o, {64'h31, 64'h32, 64'h33, 64'h34});
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        step();
        drain(4);
        check("bp_stall_cnt", stall_cnt_o, 5);

        // flush stages 0 and 1 holding A and B
        exp_q.push_back('hD); exp_q.push_back('hC);
        send('hD); send('hC); send('hB); send('hA);
        check("flush_setup", stage_data_o, {64'hD, 64'hC, 64'hB, 64'hA});
        in_valid = 1'b0; flush_i = 4'b0011;
        step();
        flush_i = '0;
        check("flush_valid", stage_valid_o, 4'b1000);
        check("flush_data", stage_data_o, {64'hC, 64'h0, 64'h0, 64'h0});
        drain(4);

        // stall and flush on the same stage
        exp_q.push_back('h51); exp_q.push_back('h53);
        send('h51); send('h52); send('h53);
        in_valid = 1'b0; stall_i = 4'b0010; flush_i = 4'b0010;
        step();
        stall_i = '0; flush_i = '0;
        check("sf_valid", stage_valid_o, 4'b1001);
        check("sf_data", stage_data_o, {64'h51, 64'h0, 64'h0, 64'h53});
        drain(4);
        check("sf_stall_cnt", stall_cnt_o, 5);

        // asynchronous reset with the chain full; 0x61..0x64 must be lost
        send('h61); send('h62); send('h63); send('h64);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("arst_valid", stage_valid_o, 0);
        check("arst_data", stage_data_o, 0);
        check("arst_stall_cnt", stall_cnt_o, 0);
        check("arst_in_ready", in_ready, 1);
        step();
        rst = 1'b1;
        exp_q.push_back('h71); exp_q.push_back('h72);
        send('h71); send('h72);
        drain(4);
        check("final_empty", stage_valid_o, 0);
        check("exp_q_empty", exp_q.size(), 0);
        done = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        done   = 1'b0;
        fork
            run_tests();
            begin : monitor
                logic [W-1:0] e;
                while (!done) begin
                    @(negedge clk);
                    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL out_beat_unexpected: got %0h expected none", out_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_beat", out_data, e);
                        end
                    end
                end
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
